// File: rtl/shift_unit_seq_pkg.sv
// Shared encodings for the multi-cycle shift unit: operation modes and FSM states.
// Also holds a small helper used when latching a request.
package shift_unit_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Only arithmetic right shifts carry the operand's sign into vacated bits.
    function automatic logic sign_fill(input logic [1:0] mode, input logic msb);
        logic fill;
        if (mode == MODE_SRA) begin
            fill = msb;
        end else begin
            fill = 1'b0;
        end
        return fill;
    endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/result handshake bundle between the shift unit and its producer/consumer.
// The master side issues requests and accepts results; the slave side is the shift unit.
interface shift_unit_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_amt,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_amt,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/shift_unit_seq_step.sv
// Combinational single-step shifter: moves a word by k bits (0..STEP) in the given mode.
// k is one bit wider than the amount field so a full-width step (STEP == WIDTH) fits.
module shift_step
    import shift_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW:0]     k_i,
    input  logic [1:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [SHW:0] WIDTH_L = (SHW+1)'(WIDTH);

    logic [SHW:0]     back_s;
    logic [WIDTH-1:0] fill_s;

    // Select the shifted word; fill_s has ones in the top k positions for sign extension.
    always_comb begin
        back_s = WIDTH_L - k_i;
        fill_s = ~({WIDTH{1'b1}} >> k_i);
        case (mode_i)
            MODE_SLL: data_o = data_i << k_i;
            MODE_SRL: data_o = data_i >> k_i;
            MODE_SRA: begin
                if (sign_i) begin
                    data_o = (data_i >> k_i) | fill_s;
                end else begin
                    data_o = data_i >> k_i;
                end
            end
            MODE_ROL: data_o = (data_i << k_i) | (data_i >> back_s);
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: accepts one request, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it. No overlap between requests.
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_unit_seq_if.slave   bus,
    output logic              busy
);

    localparam logic [SHW:0] STEP_L = (SHW+1)'(STEP);
    localparam logic [SHW:0] ZERO_L = {(SHW+1){1'b0}};

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW:0]     rem_q;
    logic [1:0]       mode_q;
    logic             sign_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;

    logic [SHW:0]     k_s;
    logic [SHW:0]     rem_left_s;
    logic [WIDTH-1:0] step_s;

    // Step size for this cycle: STEP bits, or whatever is left if that is less.
    always_comb begin
        if (rem_q > STEP_L) begin
            k_s = STEP_L;
        end else begin
            k_s = rem_q;
        end
        rem_left_s = rem_q - k_s;
    end

    shift_step #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_step (
        .data_i (work_q),
        .k_i    (k_s),
        .mode_i (mode_q),
        .sign_i (sign_q),
        .data_o (step_s)
    );

    // Control FSM with all handshake outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= {WIDTH{1'b0}};
            rem_q       <= ZERO_L;
            mode_q      <= 2'b00;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.in_data;
                        rem_q      <= {1'b0, bus.in_amt};
                        mode_q     <= bus.in_mode;
                        sign_q     <= sign_fill(bus.in_mode, bus.in_data[WIDTH-1]);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.in_amt == {SHW{1'b0}}) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= bus.in_data;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= step_s;
                    rem_q  <= rem_left_s;
                    // The final step publishes its result directly, saving a cycle.
                    if (rem_left_s == ZERO_L) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= step_s;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;

endmodule
